// File: rtl/spi_frame_ctrl.sv
// Frame sequencer between a host and an SPI master: TX/RX word FIFOs, start/cyc_count and
// per-word data feeding. Optional RX CRC-8 output enabled by SPI_FRAME_RXCRC_EN.
module spi_frame_ctrl #(
    parameter int unsigned Nd = 3,
    parameter int unsigned Nc = 6,
    parameter int unsigned Na = 4,
    parameter logic [(1 << Nd)-1:0] FILL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [Nc-1:0]         cmd_len,
    output logic                  cmd_ready,
    input  logic                  tx_wr,
    input  logic [(1 << Nd)-1:0]  tx_wdata,
    output logic                  tx_full,
    input  logic                  rx_rd,
    output logic [(1 << Nd)-1:0]  rx_rdata,
    output logic                  rx_empty,
    output logic                  done,
    output logic                  err_udf,
    output logic                  err_ovf,
    output logic                  m_start,
    output logic [Nc-1:0]         m_cyc_count,
    output logic [(1 << Nd)-1:0]  m_data_in,
    input  logic [(1 << Nd)-1:0]  m_data_out,
    input  logic                  m_data_rdy,
    input  logic                  m_busy
`ifdef SPI_FRAME_RXCRC_EN
    ,
    output logic [7:0]            rx_crc
`endif
);

    localparam int unsigned N = 1 << Nd;
    localparam int unsigned D = 1 << Na;

    typedef enum logic [2:0] {StIdle, StWait, StStart, StRun, StDone} state_t;

    state_t        state;
    logic [Nc-1:0] len_q;
    logic [Nc:0]   tx_idx;
    logic [Nc:0]   rx_idx;

    // TX FIFO
    logic [N-1:0] tx_mem [D];
    logic [Na:0]  tx_wp, tx_rp, tx_cnt;
    logic         tx_empty, tx_take, tx_pop_ok, tx_push_ok;
    logic [N-1:0] tx_word;

    // RX FIFO
    logic [N-1:0] rx_mem [D];
    logic [Na:0]  rx_wp, rx_rp;
    logic         rx_full, rx_push_req, rx_pop_ok, rx_push_ok;

    logic wait_go, more_tx;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[Na] != tx_rp[Na]) && (tx_wp[Na-1:0] == tx_rp[Na-1:0]);
    assign tx_cnt   = tx_wp - tx_rp;
    assign tx_word  = tx_empty ? FILL : tx_mem[tx_rp[Na-1:0]];

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[Na] != rx_rp[Na]) && (rx_wp[Na-1:0] == rx_rp[Na-1:0]);
    assign rx_rdata = rx_empty ? '0 : rx_mem[rx_rp[Na-1:0]];

    assign cmd_ready = (state == StIdle);

    always_comb begin
        // Long frames stream: start at once and rely on the host to keep the TX FIFO fed.
        wait_go     = (32'(len_q) > D) || (32'(tx_cnt) >= 32'(len_q));
        more_tx     = ({1'b0, len_q} > tx_idx);
        tx_take     = ((state == StWait) && wait_go && !m_busy) ||
                      ((state == StRun) && m_data_rdy && more_tx);
        tx_pop_ok   = tx_take && !tx_empty;
        tx_push_ok  = tx_wr && (!tx_full || tx_pop_ok);
        rx_push_req = (state == StRun) && m_data_rdy;
        rx_pop_ok   = rx_rd && !rx_empty;
        rx_push_ok  = rx_push_req && (!rx_full || rx_pop_ok);
    end

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem[tx_wp[Na-1:0]] <= tx_wdata;
        if (rx_push_ok) rx_mem[rx_wp[Na-1:0]] <= m_data_out;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push_ok) tx_wp <= tx_wp + 1'b1;
            if (tx_pop_ok)  tx_rp <= tx_rp + 1'b1;
            if (rx_push_ok) rx_wp <= rx_wp + 1'b1;
            if (rx_pop_ok)  rx_rp <= rx_rp + 1'b1;
        end
    end

`ifdef SPI_FRAME_RXCRC_EN
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [N-1:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            len_q       <= '0;
            tx_idx      <= '0;
            rx_idx      <= '0;
            m_start     <= 1'b0;
            m_cyc_count <= '0;
            m_data_in   <= '0;
            done        <= 1'b0;
            err_udf     <= 1'b0;
            err_ovf     <= 1'b0;
`ifdef SPI_FRAME_RXCRC_EN
            rx_crc      <= 8'h00;
`endif
        end else begin
            done    <= 1'b0;
            m_start <= 1'b0;
            case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        len_q   <= cmd_len;
                        err_udf <= 1'b0;
                        err_ovf <= 1'b0;
`ifdef SPI_FRAME_RXCRC_EN
                        rx_crc  <= 8'h00;
`endif
                        if (cmd_len == '0) done <= 1'b1;
                        else               state <= StWait;
                    end
                end
                StWait: begin
                    if (wait_go && !m_busy) begin
                        m_start     <= 1'b1;
                        m_cyc_count <= len_q;
                        m_data_in   <= tx_word;
                        if (tx_empty) err_udf <= 1'b1;
                        state       <= StStart;
                    end
                end
                StStart: begin
                    tx_idx <= {{Nc{1'b0}}, 1'b1};
                    rx_idx <= '0;
                    state  <= StRun;
                end
                StRun: begin
                    if (m_data_rdy) begin
                        rx_idx <= rx_idx + 1'b1;
                        if (!rx_push_ok) err_ovf <= 1'b1;
`ifdef SPI_FRAME_RXCRC_EN
                        rx_crc <= crc_step(rx_crc, m_data_out);
`endif
                        // Next word must be in place before the master samples it next cycle.
                        if (more_tx) begin
                            m_data_in <= tx_word;
                            tx_idx    <= tx_idx + 1'b1;
                            if (tx_empty) err_udf <= 1'b1;
                        end
                    end
                    if ((rx_idx == {1'b0, len_q}) && !m_busy) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule
